// File: rtl/ccsds_asm_randomizer.sv
// ASM insertion + CCSDS pseudo-randomizer for bit-serial LDPC codewords.
// Ports: clk, rst_n, s_axis_* (codeword in), m_axis_* (CADU out), frame_err.
// Build option: define CADU_RANDOMIZER_EN to XOR codeword bits with the PN sequence.
module ccsds_asm_randomizer #(
  parameter int                 ASM_LEN = 32,
  parameter logic [ASM_LEN-1:0] ASM     = 32'h1ACFFC1D,
  parameter int                 CW_LEN  = 8160
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_axis_tdata,
  input  logic s_axis_tvalid,
  input  logic s_axis_tlast,
  output logic s_axis_tready,
  output logic m_axis_tdata,
  output logic m_axis_tvalid,
  output logic m_axis_tlast,
  input  logic m_axis_tready,
  output logic frame_err
);

  localparam int CNT_W = $clog2(CW_LEN);

  localparam logic [0:0] S_ASM  = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [ASM_LEN-1:0] asm_sh;
  logic               load_ok;
  logic               in_hs;
  logic               cnt_last;
  logic               asm_end;
  logic               cw_end;
  logic               rbit;

  assign load_ok       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == S_DATA) && load_ok;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign cnt_last      = (cnt == CNT_W'(CW_LEN - 1));
  assign asm_end       = (cnt == CNT_W'(ASM_LEN - 1));
  assign cw_end        = s_axis_tlast || cnt_last;

`ifdef CADU_RANDOMIZER_EN
  // lfsr[7] is a[n]; lfsr[0] is a[n+7].
  logic [7:0] lfsr;

  assign rbit = lfsr[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hFF;
    end else if (state == S_ASM && load_ok && asm_end) begin
      lfsr <= 8'hFF;
    end else if (in_hs) begin
      lfsr <= {lfsr[6:0], lfsr[0] ^ lfsr[2] ^ lfsr[4] ^ lfsr[7]};
    end
  end
`else
  assign rbit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_ASM;
      cnt           <= '0;
      asm_sh        <= ASM;
      m_axis_tdata  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        S_ASM: begin
          if (load_ok) begin
            m_axis_tdata  <= asm_sh[ASM_LEN-1];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            if (asm_end) begin
              cnt    <= '0;
              asm_sh <= ASM;
              state  <= S_DATA;
            end else begin
              cnt    <= cnt + 1'b1;
              asm_sh <= {asm_sh[ASM_LEN-2:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          if (in_hs) begin
            m_axis_tdata  <= s_axis_tdata ^ rbit;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= cw_end;
            // early tlast or missing tlast at the last codeword bit
            frame_err     <= s_axis_tlast ^ cnt_last;
            if (cw_end) begin
              cnt   <= '0;
              state <= S_ASM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (load_ok) begin
            m_axis_tvalid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccsds_asm_randomizer.sv
// Self-checking bench for ccsds_asm_randomizer.
// Table of frame vectors + scoreboard queue + hand-written reset sequence.
module tb_ccsds_asm_randomizer;

  localparam int CW = 8160;
`ifdef CADU_RANDOMIZER_EN
  localparam bit RAND = 1'b1;
`else
  localparam bit RAND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tdata = 1'b0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic s_tready;
  logic m_tdata;
  logic m_tvalid;
  logic m_tlast;
  logic m_tready = 1'b1;
  logic frame_err;

  always #5 clk = ~clk;

  ccsds_asm_randomizer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .frame_err     (frame_err)
  );

  typedef struct {
    int n;
    int tl;
    bit rnd;
    bit bp;
    int err;
    int cadu;
    int tail;
  } vec_t;

  vec_t        vt [5];
  int          errors = 0;
  int          checks = 0;
  logic [1:0]  q [$];
  int          mcnt = 0;
  bit          a [263];
  bit          bp = 1'b0;
  int          fe_cnt = 0;
  int          cadu_cnt = 0;
  int          last_cadu = 0;
  logic [63:0] cap = '0;
  int          cap_n = 0;
  bit          dbits [CW];
  bit          prev_stall = 1'b0;
  logic        prev_d = 1'b0;
  logic        prev_l = 1'b0;
  logic [31:0] asm_c = 32'h1ACFFC1D;
  logic [31:0] pn_c;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endfunction

  task automatic push_asm();
    for (int i = 0; i < 32; i++)
      q.push_back({asm_c[31-i], 1'b0});
  endtask

  task automatic model_in(input logic b, input logic t);
    logic e;
    logic r;
    e = t || (mcnt == CW - 1);
    r = RAND ? a[mcnt % 255] : 1'b0;
    q.push_back({b ^ r, e});
    if (e) begin
      mcnt = 0;
      push_asm();
    end else begin
      mcnt++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: beats are accepted at the next posedge.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_beat", 64'({m_tdata, m_tlast}),
            64'({prev_d, prev_l}));
      end
      if (frame_err) begin
        fe_cnt++;
        chk("err_on_last", 64'({m_tvalid, m_tlast}), 64'd3);
      end
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0b want none", m_tdata);
        end else begin
          chk("beat", 64'({m_tdata, m_tlast}), 64'(q.pop_front()));
        end
        if (cadu_cnt >= 32 && cadu_cnt < 32 + CW)
          dbits[cadu_cnt-32] = m_tdata;
        if (cap_n < 64) begin
          cap = {cap[62:0], m_tdata};
          cap_n++;
        end
        if (m_tlast) begin
          last_cadu = cadu_cnt + 1;
          cadu_cnt = 0;
        end else begin
          cadu_cnt++;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
    end
  end

  task automatic drive_frame(input int n, input int tl,
                             input bit rnd, input int abort_at);
    int w;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      @(negedge clk);
      s_tdata  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      s_tlast  = (i == tl);
      s_tvalid = 1'b1;
      w = 0;
      forever begin
        #1;
        if (s_tready) begin
          @(posedge clk);
          model_in(s_tdata, s_tlast);
          break;
        end
        @(negedge clk);
        w++;
        if (w > 1000) begin
          checks++;
          errors++;
          $display("FAIL in_timeout: got ready=0 want ready=1");
          s_tvalid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (q.size() != 0 && c < 40000) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    int mm;
    for (int i = 0; i < 8; i++) a[i] = 1'b1;
    for (int n = 0; n < 255; n++)
      a[n+8] = a[n+7] ^ a[n+5] ^ a[n+3] ^ a[n];
    pn_c = RAND ? 32'hFF480EC0 : 32'h0;

    vt[0] = '{8160, 8159, 1'b0, 1'b0, 0, 8192, 32};
    vt[1] = '{8160, 8159, 1'b0, 1'b0, 0, 8192, 32};
    vt[2] = '{8160, 8159, 1'b1, 1'b1, 0, 8192, 32};
    vt[3] = '{100,  99,   1'b1, 1'b1, 1, 132,  32};
    vt[4] = '{8200, -1,   1'b0, 1'b0, 1, 8192, 72};

    push_asm();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      bp  = vt[v].bp;
      fe0 = fe_cnt;
      drive_frame(vt[v].n, vt[v].tl, vt[v].rnd, -1);
      wait_drain();
      chk("frame_err_cnt", 64'(fe_cnt - fe0), 64'(vt[v].err));
      chk("cadu_len", 64'(last_cadu), 64'(vt[v].cadu));
      chk("tail_beats", 64'(cadu_cnt), 64'(vt[v].tail));
      if (v == 0) begin
        chk("asm_word", 64'(cap[63:32]), 64'(asm_c));
        chk("pn_word", 64'(cap[31:0]), 64'(pn_c));
        mm = 0;
        for (int k = 0; k <= CW - 1 - 255; k++)
          if (dbits[k] != dbits[k+255]) mm++;
        chk("period", 64'(mm), 64'd0);
      end
    end

    // Reset in the middle of a frame.
    bp = 1'b0;
    drive_frame(CW, CW - 1, 1'b0, 3000);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_tdata", 64'(m_tdata), 64'd0);
    chk("mid_rst_tlast", 64'(m_tlast), 64'd0);
    chk("mid_rst_err", 64'(frame_err), 64'd0);
    q.delete();
    mcnt = 0;
    push_asm();
    cadu_cnt = 0;
    cap_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fe0 = fe_cnt;
    drive_frame(CW, CW - 1, 1'b0, -1);
    wait_drain();
    chk("post_rst_asm", 64'(cap[63:32]), 64'(asm_c));
    chk("post_rst_pn", 64'(cap[31:0]), 64'(pn_c));
    chk("post_rst_len", 64'(last_cadu), 64'd8192);
    chk("post_rst_err", 64'(fe_cnt - fe0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccsds_asm_randomizer.md
Name: ccsds_asm_randomizer

Overview:
- Sits directly downstream of the CCSDS (8160,7136) LDPC encoder.
- Consumes the encoder's bit-serial codeword stream, delimited by tlast on bit 8160.
- Prepends the 32-bit Attached Sync Marker (ASM) and XORs codeword bits with the CCSDS pseudo-randomizer sequence.
- Emits a bit-serial CADU stream (ASM + randomized codeword) to the modulator/framer interface.

Parameters:
- ASM, 32'h1ACFFC1D, sync marker, sent MSB first.
- ASM_LEN, 32, marker length in bits.
- CW_LEN, 8160, expected codeword length in bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- s_axis_tdata  input  1  codeword bit from encoder
- s_axis_tvalid  input  1  input bit valid
- s_axis_tlast  input  1  last codeword bit
- s_axis_tready  output  1  ready to accept codeword bit
- m_axis_tdata  output  1  CADU bit
- m_axis_tvalid  output  1  output bit valid
- m_axis_tlast  output  1  last CADU bit
- m_axis_tready  input  1  downstream ready
- frame_err  output  1  one-cycle pulse on codeword length mismatch

Interface: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, frame_err=0, state=S_ASM, bit counter=0, LFSR=8'hFF.
- Output stage is a single register slot.
  - The slot may load when !m_axis_tvalid || m_axis_tready.
  - A held beat keeps tdata and tlast stable until accepted.
- State S_ASM:
  - Loads ASM[ASM_LEN-1-cnt] into the output slot whenever it may load.
  - s_axis_tready=0.
  - After ASM_LEN loads: cnt=0, LFSR=8'hFF, go to S_DATA.
- State S_DATA:
  - s_axis_tready = (!m_axis_tvalid || m_axis_tready), combinational.
  - On input handshake: out bit = s_axis_tdata ^ r, where r = LFSR output bit; LFSR advances; cnt increments.
- Randomizer sequence a[n]:
  - a[0..7]=1.
  - a[n+8] = a[n+7]^a[n+5]^a[n+3]^a[n].
  - The sequence starts FF 48 0E C0 (MSB first) and has period 255.
- Codeword end: a beat ends the frame if s_axis_tlast=1 or cnt==CW_LEN-1.
  - That beat is loaded with m_axis_tlast=1.
  - Then cnt=0 and state returns to S_ASM.
- frame_err: pulses for 1 cycle, coincident with loading the frame-ending beat, when s_axis_tlast and (cnt==CW_LEN-1) disagree.
  - Covers a short frame (early tlast).
  - Covers a long frame (no tlast at bit CW_LEN); in that case the frame is forcibly closed and following input bits start a new frame.
- Throughput:
  - 1 bit/cycle with no backpressure.
  - ASM_LEN idle input cycles per frame.
  - Full CADU = ASM_LEN+CW_LEN = 8192 beats.
- Latency: 1 cycle from input handshake to m_axis_tvalid.
- m_axis_tvalid drops only when no new beat is available (S_DATA with s_axis_tvalid=0).
- Reset mid-frame: all state returns to reset values; the next output is a fresh ASM. No partial-frame recovery.

Optional Feature:
- Macro CADU_RANDOMIZER_EN.
- Defined: codeword bits are XORed with the randomizer sequence as above.
- Undefined:
  - The LFSR is not instantiated.
  - Codeword bits pass unmodified.
  - ASM insertion, tlast and frame_err behaviour are identical.

Test Plan:
- All-zero 8160-bit codeword, tready=1 -> first 32 out bits 0x1ACFFC1D; bits 33-64 = 0xFF480EC0; tlast only on beat 8192; frame_err never pulses.
- All-zero codeword -> out data bits at index k and k+255 (k=0..7904) equal (period check); two back-to-back frames each restart with 0xFF after ASM.
- Random codeword, m_axis_tready toggled pseudo-randomly (~50%) -> output stream, after de-randomizing, matches input bit-exactly; held beats stable while tvalid&&!tready.
- Input tlast on bit 100 -> frame_err pulse once; CADU of 132 beats with tlast on beat 132; next frame begins with ASM.
- 8200 bits with no tlast -> tlast and frame_err on beat 8192; remaining 40 bits appear after a new ASM.
- rst_n asserted at data bit 3000 -> outputs return to 0 immediately; after release, the stream begins with 0x1ACFFC1D. With CADU_RANDOMIZER_EN undefined, an all-zero codeword yields 8160 zero data bits.
